// File: rtl/wb_scheduler_pkg.sv
// Shared write-back definitions: requester count, field widths, write-data
// mux select codes, FSM state type, the registered command payload, and
// helpers for slicing the packed requester destination vector.
package wb_scheduler_pkg;

  localparam int unsigned DEF_NREQ    = 6;
  localparam int unsigned DEF_SP_ADDR = 29;
  localparam int unsigned ADDR_W      = 5;
  localparam int unsigned SEL_W       = 3;
  localparam int unsigned PTR_W       = 3;
  localparam int unsigned REQ_ADDR_W  = DEF_NREQ * ADDR_W;

  // Write-data mux select codes
  localparam logic [SEL_W-1:0] WD_SEL_REQ0    = 3'b000;
  localparam logic [SEL_W-1:0] WD_SEL_REQ1    = 3'b001;
  localparam logic [SEL_W-1:0] WD_SEL_REQ2    = 3'b010;
  localparam logic [SEL_W-1:0] WD_SEL_REQ3    = 3'b011;
  localparam logic [SEL_W-1:0] WD_SEL_REQ4    = 3'b100;
  localparam logic [SEL_W-1:0] WD_SEL_REQ5    = 3'b101;
  localparam logic [SEL_W-1:0] WD_SEL_SP_INIT = 3'b110;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // One register-file write command as driven to the write port
  typedef struct packed {
    logic [DEF_NREQ-1:0] gnt;
    logic [SEL_W-1:0]    wd_sel;
    logic [ADDR_W-1:0]   write_reg;
    logic                reg_write;
  } wb_cmd_t;

  // Bit offset of requester idx's destination within req_addr
  function automatic int unsigned addr_lsb(input logic [PTR_W-1:0] idx);
    return ADDR_W * 32'(idx);
  endfunction

  // Destination register of requester idx
  function automatic logic [ADDR_W-1:0] addr_of(input logic [REQ_ADDR_W-1:0] addrs,
                                                input logic [PTR_W-1:0]      idx);
    return addrs[addr_lsb(idx) +: ADDR_W];
  endfunction

  // Round-robin successor, wrapping the last requester back to 0
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] idx);
    return (idx >= PTR_W'(DEF_NREQ - 1)) ? '0 : idx + PTR_W'(1);
  endfunction

endpackage

// File: rtl/wb_scheduler_arb.sv
// rr_arbiter6: combinational round-robin pick over six requesters.
//   req      : request vector, already masked by the caller
//   p        : scan start position (0..5)
//   winner_c : one-hot winner
//   idx_c    : winner index
//   any_c    : at least one request present
module rr_arbiter6
  import wb_scheduler_pkg::*;
(
  input  logic [DEF_NREQ-1:0] req,
  input  logic [PTR_W-1:0]    p,
  output logic [DEF_NREQ-1:0] winner_c,
  output logic [PTR_W-1:0]    idx_c,
  output logic                any_c
);

  logic [PTR_W-1:0] cand;

  // Scan p, p+1, ... wrapping, and keep the first requester found
  always_comb begin
    winner_c = '0;
    idx_c    = '0;
    any_c    = 1'b0;
    cand     = '0;
    for (int unsigned k = 0; k < DEF_NREQ; k++) begin
      cand = PTR_W'((32'(p) + k) % DEF_NREQ);
      if (!any_c && req[cand]) begin
        any_c          = 1'b1;
        idx_c          = cand;
        winner_c[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_scheduler.sv
// wb_scheduler: schedules writes onto the register file's single write port.
// After reset it issues one stack-pointer initialisation write, then grants
// one requester per cycle in round-robin order.
//   clk, reset_n : clock, asynchronous active-low reset
//   hold         : stall, no new grant while high
//   req          : per-requester pending write
//   req_addr     : packed 5-bit destinations, requester i at [5i+4:5i]
//   gnt          : one-hot grant (registered)
//   wd_sel       : write-data mux select (registered)
//   write_reg    : register-file write address (registered)
//   reg_write    : register-file write enable (registered)
//   init_done    : stack-pointer initialisation write has been issued
module wb_scheduler
  import wb_scheduler_pkg::*;
#(
  parameter int unsigned NREQ    = DEF_NREQ,
  parameter int unsigned SP_ADDR = DEF_SP_ADDR
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   hold,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  output logic [NREQ-1:0]        gnt,
  output logic [SEL_W-1:0]       wd_sel,
  output logic [ADDR_W-1:0]      write_reg,
  output logic                   reg_write,
  output logic                   init_done
);

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  p_q, p_d;
  wb_cmd_t           cmd_d;
  logic              init_done_d;

  logic [NREQ-1:0]   req_m_c;
  logic [NREQ-1:0]   win_oh_c;
  logic [PTR_W-1:0]  win_idx_c;
  logic              win_any_c;
  logic [ADDR_W-1:0] win_addr_c;

  // The requester holding the grant this cycle sits out the next pick
  assign req_m_c = req & ~gnt;

  rr_arbiter6 u_arb (
    .req      (req_m_c),
    .p        (p_q),
    .winner_c (win_oh_c),
    .idx_c    (win_idx_c),
    .any_c    (win_any_c)
  );

  assign win_addr_c = addr_of(req_addr, win_idx_c);

  // Next state, pointer and write command
  always_comb begin
    state_d         = state_q;
    p_d             = p_q;
    init_done_d     = init_done;
    cmd_d.gnt       = '0;
    cmd_d.wd_sel    = wd_sel;
    cmd_d.write_reg = write_reg;
    cmd_d.reg_write = 1'b0;
    case (state_q)
      ST_INIT: begin
        cmd_d.wd_sel    = WD_SEL_SP_INIT;
        cmd_d.write_reg = ADDR_W'(SP_ADDR);
        cmd_d.reg_write = 1'b1;
        state_d         = ST_RUN;
      end
      ST_RUN: begin
        init_done_d = 1'b1;
        if (!hold && win_any_c) begin
          cmd_d.gnt       = win_oh_c;
          cmd_d.wd_sel    = win_idx_c;
          cmd_d.write_reg = win_addr_c;
          // A write to $zero is granted but never reaches the file
          cmd_d.reg_write = (win_addr_c != '0);
          p_d             = ptr_inc(win_idx_c);
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // State, pointer and output flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_INIT;
      p_q       <= '0;
      gnt       <= '0;
      wd_sel    <= '0;
      write_reg <= '0;
      reg_write <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      gnt       <= cmd_d.gnt;
      wd_sel    <= cmd_d.wd_sel;
      write_reg <= cmd_d.write_reg;
      reg_write <= cmd_d.reg_write;
      init_done <= init_done_d;
    end
  end

endmodule

// File: tb/tb_wb_scheduler.sv
// Self-checking bench for wb_scheduler: directed scenarios plus a random
// run against a small arbitration model, all via an expected-output queue.
module tb_wb_scheduler;

  typedef struct packed {
    logic [5:0] gnt;
    logic [2:0] wd_sel;
    logic [4:0] write_reg;
    logic       reg_write;
    logic       init_done;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        hold;
  logic [5:0]  req;
  logic [29:0] req_addr;
  logic [5:0]  gnt;
  logic [2:0]  wd_sel;
  logic [4:0]  write_reg;
  logic        reg_write;
  logic        init_done;

  exp_t sb[$];
  int   n_checks;
  int   n_fail;

  wb_scheduler #(.NREQ(6), .SP_ADDR(29)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .hold      (hold),
    .req       (req),
    .req_addr  (req_addr),
    .gnt       (gnt),
    .wd_sel    (wd_sel),
    .write_reg (write_reg),
    .reg_write (reg_write),
    .init_done (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic [5:0] g, input logic [2:0] s,
                              input logic [4:0] r, input logic we, input logic dn);
    exp_t e;
    e.gnt = g; e.wd_sel = s; e.write_reg = r; e.reg_write = we; e.init_done = dn;
    return e;
  endfunction

  function automatic exp_t obs();
    return mk(gnt, wd_sel, write_reg, reg_write, init_done);
  endfunction

  function automatic string show(input exp_t v);
    return $sformatf("gnt=%b sel=%0d reg=%0d we=%b done=%b",
                     v.gnt, v.wd_sel, v.write_reg, v.reg_write, v.init_done);
  endfunction

  task automatic set_addr(input int i, input logic [4:0] a);
    req_addr[i*5 +: 5] = a;
  endtask

  task automatic test_reset();
    exp_t got, want;
    for (int k = 0; k < 2; k++) begin
      sb.push_back(mk(6'b0, 3'd0, 5'd0, 1'b0, 1'b0));
      @(posedge clk); #1;
      got = obs(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %s, want %s", k, show(got), show(want));
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // req and hold are driven on the init edge and must be ignored
  task automatic test_init();
    logic [5:0] rq [2];
    logic       hd [2];
    exp_t       ex [2];
    exp_t       got, want;
    rq = '{6'h3F, 6'h00};
    hd = '{1'b1, 1'b0};
    ex[0] = mk(6'b0, 3'd6, 5'd29, 1'b1, 1'b0);
    ex[1] = mk(6'b0, 3'd6, 5'd29, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      req = rq[k]; hold = hd[k]; sb.push_back(ex[k]);
      @(posedge clk); #1;
      got = obs(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL init[%0d]: got %s, want %s", k, show(got), show(want));
      end
    end
  endtask

  task automatic test_two_req();
    logic [5:0] rq [3];
    exp_t       ex [3];
    exp_t       got, want;
    set_addr(0, 5'd8); set_addr(2, 5'd10);
    rq = '{6'b000101, 6'b000100, 6'b000000};
    ex[0] = mk(6'b000001, 3'd0, 5'd8,  1'b1, 1'b1);
    ex[1] = mk(6'b000100, 3'd2, 5'd10, 1'b1, 1'b1);
    ex[2] = mk(6'b000000, 3'd2, 5'd10, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      req = rq[k]; sb.push_back(ex[k]);
      @(posedge clk); #1;
      got = obs(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL two_req[%0d]: got %s, want %s", k, show(got), show(want));
      end
    end
  endtask

  // p is 3 here, so requester 3 beats requester 1
  task automatic test_zero_addr();
    logic [5:0] rq [2];
    exp_t       ex [2];
    exp_t       got, want;
    set_addr(1, 5'd7); set_addr(3, 5'd0);
    rq = '{6'b001010, 6'b000000};
    ex[0] = mk(6'b001000, 3'd3, 5'd0, 1'b0, 1'b1);
    ex[1] = mk(6'b000000, 3'd3, 5'd0, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      req = rq[k]; sb.push_back(ex[k]);
      @(posedge clk); #1;
      got = obs(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL zero_addr[%0d]: got %s, want %s", k, show(got), show(want));
      end
    end
  endtask

  task automatic test_back_to_back();
    int   order [7];
    exp_t got, want;
    order = '{4, 5, 0, 1, 2, 3, 4};
    for (int i = 0; i < 6; i++) set_addr(i, 5'(16 + i));
    for (int k = 0; k < 8; k++) begin
      if (k < 7) begin
        req = 6'h3F;
        sb.push_back(mk(6'(1 << order[k]), 3'(order[k]), 5'(16 + order[k]), 1'b1, 1'b1));
      end else begin
        req = 6'h00;
        sb.push_back(mk(6'b0, 3'd4, 5'd20, 1'b0, 1'b1));
      end
      @(posedge clk); #1;
      got = obs(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got %s, want %s", k, show(got), show(want));
      end
    end
  endtask

  task automatic test_single_req();
    exp_t got, want;
    req = 6'b000001;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) sb.push_back(mk(6'b000001, 3'd0, 5'd16, 1'b1, 1'b1));
      else            sb.push_back(mk(6'b000000, 3'd0, 5'd16, 1'b0, 1'b1));
      @(posedge clk); #1;
      got = obs(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL single_req[%0d]: got %s, want %s", k, show(got), show(want));
      end
    end
  endtask

  // p stays at 1 through the stall, so requester 1 wins before 2
  task automatic test_hold();
    logic [5:0] rq [6];
    logic       hd [6];
    exp_t       ex [6];
    exp_t       got, want;
    rq = '{6'b000110, 6'b000110, 6'b000110, 6'b000110, 6'b000100, 6'b000000};
    hd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ex[0] = mk(6'b000000, 3'd0, 5'd16, 1'b0, 1'b1);
    ex[1] = ex[0];
    ex[2] = ex[0];
    ex[3] = mk(6'b000010, 3'd1, 5'd17, 1'b1, 1'b1);
    ex[4] = mk(6'b000100, 3'd2, 5'd18, 1'b1, 1'b1);
    ex[5] = mk(6'b000000, 3'd2, 5'd18, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      req = rq[k]; hold = hd[k]; sb.push_back(ex[k]);
      @(posedge clk); #1;
      got = obs(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL hold[%0d]: got %s, want %s", k, show(got), show(want));
      end
    end
    hold = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [5:0] rq [4];
    exp_t       ex [4];
    exp_t       got, want;
    req = 6'b000100;
    sb.push_back(mk(6'b000100, 3'd2, 5'd18, 1'b1, 1'b1));
    @(posedge clk); #1;
    got = obs(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL reset_mid_gnt: got %s, want %s", show(got), show(want));
    end
    reset_n = 1'b0;
    sb.push_back(mk(6'b0, 3'd0, 5'd0, 1'b0, 1'b0));
    #1;
    got = obs(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %s, want %s", show(got), show(want));
    end
    req = 6'b0;
    #2 reset_n = 1'b1;
    rq = '{6'b000000, 6'b000000, 6'b111111, 6'b000000};
    ex[0] = mk(6'b000000, 3'd6, 5'd29, 1'b1, 1'b0);
    ex[1] = mk(6'b000000, 3'd6, 5'd29, 1'b0, 1'b1);
    ex[2] = mk(6'b000001, 3'd0, 5'd16, 1'b1, 1'b1);
    ex[3] = mk(6'b000000, 3'd0, 5'd16, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      req = rq[k]; sb.push_back(ex[k]);
      @(posedge clk); #1;
      got = obs(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset_mid[%0d]: got %s, want %s", k, show(got), show(want));
      end
    end
  endtask

  // Random requests, stalls and destinations against a rotate-and-pick model
  task automatic test_random();
    int          mp, mwd, mwr, lo, win;
    int          a [6];
    logic [5:0]  mg, g, r, m;
    logic [11:0] dbl, rot;
    logic        h, we;
    exp_t        got, want;
    mp = 1; mg = 6'b0; mwd = 0; mwr = 16;
    for (int c = 0; c < 60; c++) begin
      r = 6'($urandom_range(0, 63));
      h = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 6; i++) begin
        a[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 31));
        req_addr[i*5 +: 5] = 5'(a[i]);
      end
      g = 6'b0; we = 1'b0;
      if (!h) begin
        m = r & ~mg;
        if (m != 6'b0) begin
          dbl = {m, m};
          rot = dbl >> mp;
          lo = 0;
          for (int j = 5; j >= 0; j--) if (rot[j]) lo = j;
          win = (mp + lo) % 6;
          g   = 6'(1 << win);
          mwd = win;
          mwr = a[win];
          we  = (a[win] != 0);
          mp  = (win + 1) % 6;
        end
      end
      mg = g;
      req = r; hold = h;
      sb.push_back(mk(g, 3'(mwd), 5'(mwr), we, 1'b1));
      @(posedge clk); #1;
      got = obs(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL random[%0d]: got %s, want %s", c, show(got), show(want));
      end
    end
    req = 6'b0; hold = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    hold     = 1'b0;
    req      = 6'b0;
    req_addr = 30'b0;
    test_reset();
    test_init();
    test_two_req();
    test_zero_addr();
    test_back_to_back();
    test_single_req();
    test_hold();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
